// File: rtl/crc_pkg.sv
// Shared definitions for the CRC-32 frame checker: FSM state encoding,
// reflected CRC-32 polynomial, the good-frame residue and a byte-table helper.
package crc_pkg;

   // IDLE: no byte of the current frame seen; FILL: 1..3 bytes; STREAM: 4 or more.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2
   } state_e;

   localparam logic [31:0] CRC32_POLY            = 32'hEDB88320;
   localparam logic [31:0] CRC32_DEFAULT_RESIDUE = 32'hDEBB20E3;

   // Table entry for one index byte of the LSB-first CRC-32.
   // Evaluates to constant logic per index bit pattern.
   function automatic logic [31:0] crc32_table(input logic [7:0] idx);
      logic [31:0] c;
      c = {24'h000000, idx};
      for (int b = 0; b < 8; b++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_byte_update.sv
// One-byte step of the reflected CRC-32 register (purely combinational).
module crc32_byte_update
   import crc_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] crc_o
);

   // Fold the byte into the low bits, shift out one byte, XOR in table entry.
   assign crc_o = (crc_i >> 8) ^ crc32_table(crc_i[7:0] ^ byte_i);

endmodule

// File: rtl/crc32_frame_checker.sv
// CRC-32 frame checker: absorbs a byte stream terminated by a 4-byte FCS,
// reports crc_ok / crc_err / runt / frame_len with a one-cycle frame_done.
// Optional macro CRC_CHECK_STRIP_EN: hold the last 4 bytes in a delay line so
// FCS bytes are stripped from the forwarded stream; otherwise bytes pass
// straight through.
// Handshake: a byte moves in when in_valid && in_ready, and out when
// out_valid && out_ready; valid never waits on ready from the same side.
module crc32_frame_checker
   import crc_pkg::*;
#(
   parameter logic [31:0] INITIAL_CRC     = 32'hFFFFFFFF,
   parameter logic [31:0] RESIDUE         = CRC32_DEFAULT_RESIDUE,
   parameter int unsigned MIN_FRAME_BYTES = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_last,
   input  logic        out_ready,
   output logic        frame_done,
   output logic        crc_ok,
   output logic        crc_err,
   output logic        runt,
   output logic [15:0] frame_len,
   output logic [1:0]  state_dbg
);

   localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);

   logic        accept;
   state_e      state_q, state_d;
   logic [31:0] crc_q, crc_d, crc_next;
   logic [15:0] len_q, len_d, len_next;
   logic        long_enough, good_frame;

   logic        done_q, ok_q, err_q, runt_q;
   logic [15:0] flen_q;

   assign accept = in_valid && in_ready;

   crc32_byte_update u_crc_update (
      .crc_i  (crc_q),
      .byte_i (in_data),
      .crc_o  (crc_next)
   );

   // Length of the frame including the byte being accepted; sticks at 16'hFFFF.
   assign len_next    = (len_q == 16'hFFFF) ? len_q : (len_q + 16'd1);
   assign long_enough = (len_next >= MIN_LEN);
   assign good_frame  = (crc_next == RESIDUE) && long_enough;

   // Next-state logic: count the frame's first bytes, return to IDLE on the last byte.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         if (in_last) begin
            state_d = IDLE;
         end else begin
            case (state_q)
               IDLE:    state_d = FILL;
               FILL:    if (len_q == 16'd3) state_d = STREAM;
               default: state_d = STREAM;
            endcase
         end
      end
   end

   // Running CRC and length; both re-preset on the last byte so the next frame starts clean.
   always_comb begin
      crc_d = crc_q;
      len_d = len_q;
      if (accept) begin
         if (in_last) begin
            crc_d = INITIAL_CRC;
            len_d = 16'd0;
         end else begin
            crc_d = crc_next;
            len_d = len_next;
         end
      end
   end

   // State, CRC register and running length.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         crc_q   <= INITIAL_CRC;
         len_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         len_q   <= len_d;
      end
   end

   // Frame verdict: pulse done one cycle after the last byte, hold status until the next one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_q <= 1'b0;
         ok_q   <= 1'b0;
         err_q  <= 1'b0;
         runt_q <= 1'b0;
         flen_q <= 16'd0;
      end else begin
         done_q <= accept && in_last;
         if (accept && in_last) begin
            ok_q   <= good_frame;
            err_q  <= !good_frame;
            runt_q <= !long_enough;
            flen_q <= len_next;
         end
      end
   end

   assign frame_done = done_q;
   assign crc_ok     = ok_q;
   assign crc_err    = err_q;
   assign runt       = runt_q;
   assign frame_len  = flen_q;
   assign state_dbg  = state_q;

`ifdef CRC_CHECK_STRIP_EN
   // line_q[0] is the oldest held byte; it leaves when a fifth byte arrives.
   logic [3:0][7:0] line_q, line_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            line_full;

   assign line_full = (cnt_q == 3'd4);
   assign in_ready  = !reset && (out_ready || !line_full);
   assign out_valid = in_valid && line_full;
   assign out_last  = in_valid && in_last && line_full;
   assign out_data  = line_q[0];

   // Delay-line update: fill up to four bytes, then shift; the last byte empties it (drops FCS).
   always_comb begin
      line_d = line_q;
      cnt_d  = cnt_q;
      if (accept) begin
         if (line_full) begin
            line_d = {in_data, line_q[3], line_q[2], line_q[1]};
         end else begin
            line_d[cnt_q[1:0]] = in_data;
         end
         if (in_last) begin
            cnt_d = 3'd0;
         end else if (!line_full) begin
            cnt_d = cnt_q + 3'd1;
         end
      end
   end

   // Delay-line storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_q <= '0;
         cnt_q  <= 3'd0;
      end else begin
         line_q <= line_d;
         cnt_q  <= cnt_d;
      end
   end
`else
   // Pass-through: every byte, FCS included, goes straight out; quiet while in reset.
   assign in_ready  = out_ready && !reset;
   assign out_valid = in_valid && !reset;
   assign out_last  = in_last && !reset;
   assign out_data  = reset ? 8'h00 : in_data;
`endif

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Self-checking bench for crc32_frame_checker (works with or without CRC_CHECK_STRIP_EN).
module tb_crc32_frame_checker;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_ready = 1'b0;
   logic        frame_done, crc_ok, crc_err, runt;
   logic [15:0] frame_len;
   logic [1:0]  state_dbg;

   int checks = 0;
   int failures = 0;
   int or_mode = 1;        // 0 random, 1 always ready, 2 pattern 1,0,0,1
   int pat_idx = 0;
   int cycle = 0;
   int done_count = 0;
   int exp_done = 0;

   logic [8:0]  exp_q[$];   // {last, data} expected on the output port
   logic [18:0] stat_q[$];  // {ok, err, runt, len} expected at frame_done
   int          done_cyc[$];
   logic [7:0]  frame_q[$];

   localparam logic [18:0] ST_GOOD13 = {1'b1, 1'b0, 1'b0, 16'd13};
   localparam logic [18:0] ST_BAD13  = {1'b0, 1'b1, 1'b0, 16'd13};

   crc32_frame_checker dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .frame_done(frame_done), .crc_ok(crc_ok), .crc_err(crc_err), .runt(runt),
      .frame_len(frame_len), .state_dbg(state_dbg)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // ---------------- reference model ----------------
   // Bit-serial reflected CRC-32 register over the whole frame buffer.
   function automatic logic [31:0] model_reg();
      logic [31:0] r;
      logic fb;
      r = 32'hFFFFFFFF;
      foreach (frame_q[i]) begin
         for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ frame_q[i][k];
            r = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
         end
      end
      return r;
   endfunction

   function automatic logic [18:0] model_status();
      logic [31:0] r;
      int L;
      logic ok;
      r = model_reg();
      L = frame_q.size();
      ok = (r == 32'hDEBB20E3) && (L >= 5);
      return {ok, !ok, (L < 5), 16'(L)};
   endfunction

   task automatic append_fcs();
      logic [31:0] f;
      f = ~model_reg();
      frame_q.push_back(f[7:0]);
      frame_q.push_back(f[15:8]);
      frame_q.push_back(f[23:16]);
      frame_q.push_back(f[31:24]);
   endtask

   task automatic build_golden();
      frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'h26, 8'h39, 8'hF4, 8'hCB};
   endtask

   // ---------------- driver ----------------
   // Sends frame_q; abort_after >= 0 stops after that many accepted bytes (no in_last).
   task automatic send_frame(input int abort_after, input int gap_pct, input logic [18:0] exp_status);
      int L, n, fwd, t;
      bit complete;
      L = frame_q.size();
      complete = (abort_after < 0);
      n = complete ? L : abort_after;
`ifdef CRC_CHECK_STRIP_EN
      fwd = (n > 4) ? n - 4 : 0;
`else
      fwd = n;
`endif
      for (int i = 0; i < fwd; i++) exp_q.push_back({complete && (i == fwd - 1), frame_q[i]});
      if (complete) begin
         stat_q.push_back(exp_status);
         exp_done++;
      end
      for (int i = 0; i < n; i++) begin
         while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = frame_q[i];
         in_last  = complete && (i == L - 1);
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!in_ready && t < 1000);
         if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: in_ready stuck 0 for %0d cycles, required 1", t);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- out_ready generator ----------------
   initial begin
      forever begin
         @(posedge clk); #1;
         case (or_mode)
            0: out_ready = ($urandom_range(0, 3) != 0);
            1: out_ready = 1'b1;
            default: begin
               out_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
               pat_idx++;
            end
         endcase
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [8:0]  eb;
      logic [18:0] es;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL out_unexpected: got last=%b data=%h, required no output", out_last, out_data);
               end else begin
                  eb = exp_q.pop_front();
                  check("out_byte", {23'd0, out_last, out_data}, {23'd0, eb});
               end
            end
            if (frame_done) begin
               done_count++;
               done_cyc.push_back(cycle);
               if (stat_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL done_unexpected: frame_done=1 len=%0d, required no pulse", frame_len);
               end else begin
                  es = stat_q.pop_front();
                  check("status", {13'd0, crc_ok, crc_err, runt, frame_len}, {13'd0, es});
               end
            end
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      int plen, kind;
      repeat (3) @(posedge clk);
      @(negedge clk);
      // reset values (out_ready is 1 here, so in_ready must still be held low)
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_flags", {28'd0, frame_done, crc_ok, crc_err, runt}, 32'd0);
      check("rst_frame_len", {16'd0, frame_len}, 32'd0);
      check("rst_state", {30'd0, state_dbg}, 32'd0);
      reset = 1'b0;
      idle(2);

      // known-good "123456789" + FCS
      build_golden();
      send_frame(-1, 0, ST_GOOD13);
      idle(6);
      check("held_crc_ok", {31'd0, crc_ok}, 32'd1);
      check("held_len", {16'd0, frame_len}, 32'd13);

      // single corrupted byte
      build_golden();
      frame_q[4] = 8'h34;
      send_frame(-1, 0, ST_BAD13);
      idle(4);

      // 3-byte runt and 1-byte runt
      frame_q = '{8'hAA, 8'hBB, 8'hCC};
      send_frame(-1, 0, {1'b0, 1'b1, 1'b1, 16'd3});
      frame_q = '{8'h5A};
      send_frame(-1, 0, {1'b0, 1'b1, 1'b1, 16'd1});
      idle(4);

      // backpressure pattern 1,0,0,1
      or_mode = 2;
      build_golden();
      send_frame(-1, 0, ST_GOOD13);
      idle(6);

      // back-to-back, in_valid held high, always ready
      or_mode = 1;
      idle(2);
      done_cyc.delete();
      build_golden();
      send_frame(-1, 0, ST_GOOD13);
      build_golden();
      send_frame(-1, 0, ST_GOOD13);
      idle(4);
      check("b2b_pulses", done_cyc.size(), 32'd2);
      if (done_cyc.size() == 2) check("b2b_spacing", done_cyc[1] - done_cyc[0], 32'd13);

      // reset after 6 bytes, then a good frame
      or_mode = 0;
      build_golden();
      send_frame(6, 0, ST_GOOD13);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      check("midrst_crc_ok", {31'd0, crc_ok}, 32'd0);
      check("midrst_len", {16'd0, frame_len}, 32'd0);
      check("midrst_state", {30'd0, state_dbg}, 32'd0);
      idle(2);
      reset = 1'b0;
      idle(1);
      build_golden();
      send_frame(-1, 0, ST_GOOD13);

      // length boundaries: FCS-only frame (4 bytes, runt) and 1-byte payload (5 bytes, ok)
      frame_q.delete();
      append_fcs();
      send_frame(-1, 10, model_status());
      frame_q = '{8'($urandom_range(255))};
      append_fcs();
      send_frame(-1, 10, model_status());

      // random frames under random backpressure and input gaps
      for (int f = 0; f < 30; f++) begin
         frame_q.delete();
         kind = $urandom_range(0, 5);
         plen = (kind == 0) ? $urandom_range(1, 4) : $urandom_range(0, 24);
         for (int i = 0; i < plen; i++) frame_q.push_back(8'($urandom_range(255)));
         if (kind != 0) begin
            append_fcs();
            if (kind == 1) frame_q[$urandom_range(0, frame_q.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
         end
         send_frame(-1, 20, model_status());
      end

      idle(30);
      check("out_queue_drained", exp_q.size(), 32'd0);
      check("status_queue_drained", stat_q.size(), 32'd0);
      check("done_count", done_count, exp_done);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
